pipeline_hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 27 ++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the decode-stage hazard controller:
//   - ctrl_state_t : controller FSM states (RUN, FLUSH, MEM_WAIT)
//   - OP_*         : RV32I major opcodes needed for register-use decode
//   - REG_ADDR_W   : architectural register index width
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Encoding 2'd3 is unused; the FSM treats it as a corrupted state.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. Flags when the load in E
// writes a register that the instruction in D actually reads.
// Ports:
//   InstrD    in  32          instruction in decode
//   MemReadE  in  1           instruction in E is a load
//   RdE       in  REG_ADDR_W  destination register of the instruction in E
//   load_use  out 1           D must wait one cycle for the load result
// ---------------------------------------------------------------------------
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [31:0]           InstrD,
  input  logic                  MemReadE,
  input  logic [REG_ADDR_W-1:0] RdE,
  output logic                  load_use
);

  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1Used;
  logic                  rs2Used;
  logic                  unusedInstrBits;

  assign opcode = InstrD[6:0];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];

  // funct/imm/rd fields play no part in hazard detection.
  assign unusedInstrBits = ^{InstrD[31:25], InstrD[14:7]};

  // The rs fields of U/J-type instructions hold immediate bits, and the rs2
  // field of I-type instructions is immediate too, so a match there would be
  // a false hazard.
  assign rs1Used = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2Used = opcode inside {OP_R, OP_STORE, OP_BRANCH};

  // x0 is hard-wired, so a load "to x0" never produces a dependency.
  assign load_use = MemReadE && (RdE != '0) &&
                    ((rs1Used && (RdE == rs1)) || (rs2Used && (RdE == rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush controller for the IF/ID and ID/EX pipeline registers.
// Handles load-use hazards, taken-branch redirects (flushing for FLUSH_CYCLES
// cycles) and data-memory wait states, and keeps saturating performance
// counters of stalled and flushed cycles.
// Parameters:
//   FLUSH_CYCLES  cycles FlushD/FlushE stay high per taken branch (1..3)
//   CNT_W         performance counter width
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   InstrD        instruction in decode
//   MemReadE, RdE load indication and destination register of E
//   BranchTakenM  branch resolved taken in M
//   mem_req       data-memory access in progress in M
//   mem_ready     data memory completes its access this cycle
//   StallF/D/E    hold PC, IF/ID, ID/EX
//   FlushD/E      clear IF/ID to NOP, inject bubble into ID/EX
//   ctrl_state    current FSM state
//   stall_cnt     saturating count of StallF cycles
//   flush_cnt     saturating count of FlushD cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           InstrD,
  input  logic                  MemReadE,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  BranchTakenM,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Cycles still to flush after the branch cycle itself.
  localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  ctrl_state_t state;
  ctrl_state_t stateNext;
  logic [1:0]  flushLeft;
  logic [1:0]  flushLeftNext;
  logic        loadUse;
  logic        memStall;
  logic        applyRunRules;

  load_use_detect u_load_use_detect (
    .InstrD   (InstrD),
    .MemReadE (MemReadE),
    .RdE      (RdE),
    .load_use (loadUse)
  );

  assign memStall   = mem_req && !mem_ready;
  assign ctrl_state = state;

  // NOTE: every signal assigned here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    stateNext     = state;
    flushLeftNext = flushLeft;
    applyRunRules = 1'b0;
    StallF        = 1'b0;
    StallD        = 1'b0;
    StallE        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;

    case (state)
      RUN: begin
        if (memStall) begin
          // The M-stage access wins over everything: freeze the whole front.
          {StallF, StallD, StallE} = 3'b111;
          stateNext                = MEM_WAIT;
        end else begin
          applyRunRules = 1'b1;
        end
      end

      FLUSH: begin
        if (memStall) begin
          // Flushing is paused, not abandoned: counter holds its value.
          {StallF, StallD, StallE} = 3'b111;
        end else begin
          FlushD = 1'b1;
          FlushE = 1'b1;
          if (BranchTakenM) begin
            flushLeftNext = FLUSH_RELOAD;
          end else if (flushLeft <= 2'd1) begin
            flushLeftNext = 2'd0;
            stateNext     = RUN;
          end else begin
            flushLeftNext = flushLeft - 2'd1;
          end
        end
      end

      MEM_WAIT: begin
        if (!mem_ready) begin
          {StallF, StallD, StallE} = 3'b111;
        end else begin
          // The access completes now, so the pipeline moves this cycle and
          // any branch or load-use seen meanwhile is handled immediately.
          stateNext     = RUN;
          applyRunRules = 1'b1;
        end
      end

      default: begin
        stateNext     = RUN;
        flushLeftNext = 2'd0;
      end
    endcase

    if (applyRunRules) begin
      if (BranchTakenM) begin
        // The D instruction is wrong-path, so its load-use is irrelevant.
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          flushLeftNext = FLUSH_RELOAD;
          stateNext     = FLUSH;
        end
      end else if (loadUse) begin
        // The bubble clears MemReadE next cycle, so this lasts one cycle.
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end

    if (!rst) begin
      {StallF, StallD, StallE, FlushD, FlushE} = 5'b00000;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      flushLeft <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= stateNext;
      flushLeft <= flushLeftNext;
      if (StallF && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (FlushD && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Two controllers share one stimulus stream: A (FLUSH_CYCLES=3, CNT_W=4)
// and B (FLUSH_CYCLES=1, CNT_W=16). A reference model tracks, per instance,
// remaining flush cycles, whether a memory wait is outstanding and the two
// counts, and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic        MemReadE;
  logic [4:0]  RdE;
  logic        BranchTakenM;
  logic        mem_req;
  logic        mem_ready;

  logic        aStallF, aStallD, aStallE, aFlushD, aFlushE;
  logic [1:0]  aState;
  logic [3:0]  aStallCnt, aFlushCnt;
  logic        bStallF, bStallD, bStallE, bFlushD, bFlushE;
  logic [1:0]  bState;
  logic [15:0] bStallCnt, bFlushCnt;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dutA (
    .clk(clk), .rst(rst), .InstrD(InstrD), .MemReadE(MemReadE), .RdE(RdE),
    .BranchTakenM(BranchTakenM), .mem_req(mem_req), .mem_ready(mem_ready),
    .StallF(aStallF), .StallD(aStallD), .StallE(aStallE),
    .FlushD(aFlushD), .FlushE(aFlushE), .ctrl_state(aState),
    .stall_cnt(aStallCnt), .flush_cnt(aFlushCnt)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dutB (
    .clk(clk), .rst(rst), .InstrD(InstrD), .MemReadE(MemReadE), .RdE(RdE),
    .BranchTakenM(BranchTakenM), .mem_req(mem_req), .mem_ready(mem_ready),
    .StallF(bStallF), .StallD(bStallD), .StallE(bStallE),
    .FlushD(bFlushD), .FlushE(bFlushE), .ctrl_state(bState),
    .stall_cnt(bStallCnt), .flush_cnt(bFlushCnt)
  );

  // ---------------- reference model ----------------
  int fcOf[2]     = '{3, 1};
  int cntMaxOf[2] = '{15, 65535};
  int flushRem[2], nRem[2];
  bit waiting[2], nWait[2];
  int stallCount[2], nStallCount[2];
  int flushCount[2], nFlushCount[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit refLoadUse(logic [31:0] instr, bit memRead, logic [4:0] rd);
    logic [6:0] op = instr[6:0];
    bit readsRs1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    bit readsRs2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    return memRead && (rd != 5'd0) &&
           ((readsRs1 && rd == instr[19:15]) || (readsRs2 && rd == instr[24:20]));
  endfunction

  // outs = {StallF, StallD, StallE, FlushD, FlushE}
  task automatic evalModel(input int i, output logic [4:0] outs);
    bit stall;
    outs     = 5'b00000;
    nRem[i]  = flushRem[i];
    nWait[i] = waiting[i];
    if (!rst) begin
      nRem[i] = 0; nWait[i] = 0; nStallCount[i] = 0; nFlushCount[i] = 0;
      return;
    end
    stall = waiting[i] ? !mem_ready : (mem_req && !mem_ready);
    if (stall) begin
      outs = 5'b11100;
      if (flushRem[i] == 0) nWait[i] = 1;
    end else begin
      nWait[i] = 0;
      if (BranchTakenM) begin
        outs = 5'b00011; nRem[i] = fcOf[i] - 1;
      end else if (flushRem[i] > 0) begin
        outs = 5'b00011; nRem[i] = flushRem[i] - 1;
      end else if (refLoadUse(InstrD, MemReadE, RdE)) begin
        outs = 5'b11001;
      end
    end
    nStallCount[i] = stallCount[i] + ((outs[4] && stallCount[i] < cntMaxOf[i]) ? 1 : 0);
    nFlushCount[i] = flushCount[i] + ((outs[1] && flushCount[i] < cntMaxOf[i]) ? 1 : 0);
  endtask

  function automatic int modelState(int i);
    return waiting[i] ? 2 : (flushRem[i] > 0 ? 1 : 0);
  endfunction

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic step(input string tag);
    logic [4:0] expA, expB;
    @(negedge clk);
    evalModel(0, expA);
    evalModel(1, expB);
    check({tag, "/A outs"},  {aStallF, aStallD, aStallE, aFlushD, aFlushE}, expA);
    check({tag, "/A state"}, aState,    modelState(0));
    check({tag, "/A stall_cnt"}, aStallCnt, stallCount[0]);
    check({tag, "/A flush_cnt"}, aFlushCnt, flushCount[0]);
    check({tag, "/B outs"},  {bStallF, bStallD, bStallE, bFlushD, bFlushE}, expB);
    check({tag, "/B state"}, bState,    modelState(1));
    check({tag, "/B stall_cnt"}, bStallCnt, stallCount[1]);
    check({tag, "/B flush_cnt"}, bFlushCnt, flushCount[1]);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      flushRem[i]   = nRem[i];
      waiting[i]    = nWait[i];
      stallCount[i] = nStallCount[i];
      flushCount[i] = nFlushCount[i];
    end
    #1;
  endtask

  task automatic setIdle();
    rst          = 1'b1;
    InstrD       = 32'h0000_0013;  // addi x0,x0,0
    MemReadE     = 1'b0;
    RdE          = 5'd0;
    BranchTakenM = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
  endtask

  task automatic doReset(input string tag);
    setIdle();
    rst = 1'b0;
    step(tag);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rType(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  logic [6:0] opList[9] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011,
                            7'b1100111};

  initial begin
    logic [31:0] instr;

    // Bring the DUTs out of X before the first checked cycle.
    setIdle();
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      flushRem[i] = 0; waiting[i] = 0; stallCount[i] = 0; flushCount[i] = 0;
    end
    doReset("reset");

    // Load-use: add x7,x5,x6 behind a load to x5.
    InstrD = rType(5'd7, 5'd5, 5'd6); MemReadE = 1'b1; RdE = 5'd5;
    step("loaduse");
    MemReadE = 1'b0;
    step("loaduse_bubble");
    check("loaduse A stall_cnt", aStallCnt, 1);
    check("loaduse B stall_cnt", bStallCnt, 1);

    // No false hazards.
    InstrD = rType(5'd1, 5'd0, 5'd2); MemReadE = 1'b1; RdE = 5'd0;
    step("nohaz_x0");
    InstrD = {20'h00001, 5'd6, 7'b0110111}; RdE = 5'd6;
    step("nohaz_lui");
    InstrD = {12'd6, 5'd2, 3'b000, 5'd1, 7'b0010011};
    step("nohaz_addi");
    check("nohaz A stall_cnt", aStallCnt, 1);
    MemReadE = 1'b0;

    // Taken branch pulse.
    doReset("reset_br");
    BranchTakenM = 1'b1;
    step("branch");
    check("branch A state FLUSH", aState, 1);
    BranchTakenM = 1'b0;
    for (int k = 0; k < 3; k++) step("branch_drain");
    check("branch A flush_cnt", aFlushCnt, 3);
    check("branch B flush_cnt", bFlushCnt, 1);
    check("branch A state RUN", aState, 0);

    // Memory wait while a branch is pending.
    doReset("reset_mem");
    mem_req = 1'b1; mem_ready = 1'b0; BranchTakenM = 1'b1;
    for (int k = 0; k < 4; k++) step("memwait");
    mem_ready = 1'b1;
    step("memready_branch");
    mem_req = 1'b0; mem_ready = 1'b0; BranchTakenM = 1'b0;
    for (int k = 0; k < 3; k++) step("memwait_drain");
    check("memwait A stall_cnt", aStallCnt, 4);
    check("memwait B stall_cnt", bStallCnt, 4);
    check("memwait A flush_cnt", aFlushCnt, 3);

    // Reset during the second FLUSH cycle.
    doReset("reset_mid0");
    BranchTakenM = 1'b1;
    step("midflush_br");
    BranchTakenM = 1'b0;
    step("midflush_f1");
    rst = 1'b0;
    step("midflush_rst");
    rst = 1'b1;
    check("midflush A state", aState, 0);
    check("midflush A flush_cnt", aFlushCnt, 0);
    step("midflush_after");

    // Counter saturation.
    doReset("reset_sat");
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 20; k++) step("saturate");
    check("sat A stall_cnt", aStallCnt, 15);
    check("sat B stall_cnt", bStallCnt, 20);
    mem_ready = 1'b1;
    step("sat_release");

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      instr        = $urandom();
      instr[6:0]   = opList[$urandom_range(0, 8)];
      instr[19:15] = 5'($urandom_range(0, 7));
      instr[24:20] = 5'($urandom_range(0, 7));
      InstrD       = instr;
      MemReadE     = ($urandom_range(0, 2) == 0);
      RdE          = 5'($urandom_range(0, 7));
      BranchTakenM = ($urandom_range(0, 7) == 0);
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = ($urandom_range(0, 1) == 0);
      rst          = ($urandom_range(0, 63) != 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
